// File: rtl/sccb_config.sv
// sccb_config: writes a fixed OV7670 register table over SCCB (3-phase
// writes: device ID, sub-address, data) after a rising edge on i_start_i2c,
// then holds o_done high until the next accepted start or a reset.
// Bus outputs are decoded from registered state, so a reset returns the
// bus to idle (SIOC high, SIOD released) immediately.
module sccb_config #(
  parameter int unsigned CLK_DIV    = 125,
  parameter logic [7:0]  DEV_ADDR   = 8'h42,
  parameter int unsigned RESET_WAIT = 50000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start_i2c,
  output logic       o_sioc,
  output logic       o_siod_oe,
  output logic       o_busy,
  output logic       o_done,
  output logic [3:0] o_reg_index
);

  localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int WW = (RESET_WAIT > 1) ? $clog2(RESET_WAIT) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(CLK_DIV - 1);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(RESET_WAIT - 1);
  localparam logic [4:0]    LAST_BIT   = 5'd26;
  localparam logic [2:0]    LAST_ENTRY = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BITS,
    S_STOP,
    S_GAP,
    S_WAIT_RST,
    S_DONE
  } state_t;

  state_t          r_state, w_next_state;
  logic [1:0]      r_q, w_next_q;
  logic [4:0]      r_bit, w_next_bit;
  logic [2:0]      r_idx, w_next_idx;
  logic            r_start_d;
  logic [TW-1:0]   r_tick_cnt;
  logic [WW-1:0]   r_wait_cnt;

  logic            w_start_rise;
  logic            w_tick;
  logic            w_wait_done;
  logic            w_running;
  logic [15:0]     w_entry;
  logic [26:0]     w_frame;
  logic            w_bit_val;

  // Register table: {sub-address, data} per entry, written in index order.
  function automatic logic [15:0] f_entry(input logic [2:0] idx);
    case (idx)
      3'd0:    f_entry = 16'h1280;
      3'd1:    f_entry = 16'h1204;
      3'd2:    f_entry = 16'h40D0;
      3'd3:    f_entry = 16'h8C00;
      3'd4:    f_entry = 16'h1101;
      3'd5:    f_entry = 16'h3A04;
      3'd6:    f_entry = 16'h0C00;
      default: f_entry = 16'h3E00;
    endcase
  endfunction

  // The don't-care 9th bit of each phase is stored as 1 so SIOD is released.
  assign w_entry      = f_entry(r_idx);
  assign w_frame      = {DEV_ADDR, 1'b1, w_entry[15:8], 1'b1, w_entry[7:0], 1'b1};
  assign w_bit_val    = w_frame[LAST_BIT - r_bit];
  assign w_start_rise = i_start_i2c & ~r_start_d;
  assign w_tick       = (r_tick_cnt == TICK_LAST);
  assign w_wait_done  = (r_wait_cnt == WAIT_LAST);
  assign w_running    = (r_state != S_IDLE) && (r_state != S_DONE) && (r_state != S_WAIT_RST);
  assign o_reg_index  = {1'b0, r_idx};

  // Registered copy of the start request for rising-edge detection.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_start_d <= 1'b0;
    else          r_start_d <= i_start_i2c;
  end

  // Quarter-bit tick divider; parked at zero whenever the bus is not being driven.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)       r_tick_cnt <= '0;
    else if (!w_running) r_tick_cnt <= '0;
    else if (w_tick)     r_tick_cnt <= '0;
    else                 r_tick_cnt <= r_tick_cnt + TW'(1);
  end

  // Post-soft-reset delay counter, measured in raw clock cycles.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                  r_wait_cnt <= '0;
    else if (r_state != S_WAIT_RST) r_wait_cnt <= '0;
    else                            r_wait_cnt <= r_wait_cnt + WW'(1);
  end

  // Sequencer state, sub-tick position, bit position and table index.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_q     <= 2'd0;
      r_bit   <= 5'd0;
      r_idx   <= 3'd0;
    end else begin
      r_state <= w_next_state;
      r_q     <= w_next_q;
      r_bit   <= w_next_bit;
      r_idx   <= w_next_idx;
    end
  end

  // Next-state sequencing and bus/status output decode.
  always_comb begin
    w_next_state = r_state;
    w_next_q     = r_q;
    w_next_bit   = r_bit;
    w_next_idx   = r_idx;
    o_sioc       = 1'b1;
    o_siod_oe    = 1'b0;
    o_busy       = (r_state != S_IDLE) && (r_state != S_DONE);
    o_done       = (r_state == S_DONE);

    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_start_rise) begin
          w_next_state = S_START;
          w_next_q     = 2'd0;
          w_next_bit   = 5'd0;
          w_next_idx   = 3'd0;
        end
      end
      S_START: begin
        o_siod_oe = 1'b1;
        o_sioc    = (r_q == 2'd0);
        if (w_tick) begin
          if (r_q == 2'd1) begin
            w_next_state = S_BITS;
            w_next_q     = 2'd0;
            w_next_bit   = 5'd0;
          end else begin
            w_next_q = r_q + 2'd1;
          end
        end
      end
      S_BITS: begin
        o_siod_oe = ~w_bit_val;
        o_sioc    = (r_q == 2'd1) || (r_q == 2'd2);
        if (w_tick) begin
          w_next_q = r_q + 2'd1;
          if (r_q == 2'd3) begin
            if (r_bit == LAST_BIT) w_next_state = S_STOP;
            else                   w_next_bit   = r_bit + 5'd1;
          end
        end
      end
      S_STOP: begin
        o_siod_oe = (r_q != 2'd2);
        o_sioc    = (r_q != 2'd0);
        if (w_tick) begin
          if (r_q == 2'd2) begin
            w_next_state = S_GAP;
            w_next_q     = 2'd0;
          end else begin
            w_next_q = r_q + 2'd1;
          end
        end
      end
      S_GAP: begin
        if (w_tick) begin
          w_next_q = r_q + 2'd1;
          if (r_q == 2'd3) begin
            if (r_idx == 3'd0) begin
              w_next_state = S_WAIT_RST;
            end else if (r_idx == LAST_ENTRY) begin
              w_next_state = S_DONE;
            end else begin
              w_next_state = S_START;
              w_next_idx   = r_idx + 3'd1;
            end
          end
        end
      end
      S_WAIT_RST: begin
        if (w_wait_done) begin
          w_next_state = S_START;
          w_next_q     = 2'd0;
          w_next_idx   = r_idx + 3'd1;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sccb_config.sv
// tb_sccb_config: randomized start stimulus against a cycle-level waveform
// model plus a bus-level SCCB decoder that rebuilds every frame from the
// SIOC/SIOD lines.
module tb_sccb_config;

  localparam int D     = 4;
  localparam int W     = 100;
  localparam int ENTRY = 117 * D;
  localparam int TOTAL = 8 * ENTRY + W;
  localparam logic [7:0] DEV = 8'h42;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       sioc;
  logic       oe;
  logic       busy;
  logic       done;
  logic [3:0] idx;

  logic [7:0] subTab [8] = '{8'h12, 8'h12, 8'h40, 8'h8C, 8'h11, 8'h3A, 8'h0C, 8'h3E};
  logic [7:0] datTab [8] = '{8'h80, 8'h04, 8'hD0, 8'h00, 8'h01, 8'h04, 8'h00, 8'h00};

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  sccb_config #(.CLK_DIV(D), .DEV_ADDR(DEV), .RESET_WAIT(W)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start_i2c (start),
    .o_sioc      (sioc),
    .o_siod_oe   (oe),
    .o_busy      (busy),
    .o_done      (done),
    .o_reg_index (idx)
  );

  // 10-unit system clock.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic startVal, input int cycles);
    start = startVal;
    repeat (cycles) @(negedge clk);
  endtask

  // Bounded wait: sel 0 = busy, 1 = done, 2 = reg_index==3.
  task automatic waitSig(input string name, input int sel, input logic lvl, input int maxC);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < maxC && !hit; i++) begin
      @(negedge clk);
      case (sel)
        0:       hit = (busy === lvl);
        1:       hit = (done === lvl);
        default: hit = (idx === 4'd3);
      endcase
    end
    checkOutput(name, {31'd0, hit}, 32'd1);
    #1;
  endtask

  // Expected {sioc, siod_oe, busy, done, reg_index} from elapsed cycles of a run.
  function automatic logic [7:0] expOut(input bit act, input bit dn, input int t);
    int entry, off, u, b, q, s, pos;
    logic [7:0] by;
    logic sc, od;
    if (!act) return {1'b1, 1'b0, 1'b0, dn, (dn ? 4'd7 : 4'd0)};
    if (t < ENTRY) begin
      entry = 0;
      off   = t;
    end else if (t < ENTRY + W) begin
      return {1'b1, 1'b0, 1'b1, 1'b0, 4'd0};
    end else begin
      entry = 1 + (t - ENTRY - W) / ENTRY;
      off   = (t - ENTRY - W) % ENTRY;
    end
    u  = off / D;
    sc = 1'b1;
    od = 1'b0;
    if (u < 2) begin
      od = 1'b1;
      sc = (u == 0);
    end else if (u < 110) begin
      b   = (u - 2) / 4;
      q   = (u - 2) % 4;
      pos = b % 9;
      case (b / 9)
        0:       by = DEV;
        1:       by = subTab[entry];
        default: by = datTab[entry];
      endcase
      od = (pos == 8) ? 1'b0 : ~by[7 - pos];
      sc = (q == 1) || (q == 2);
    end else if (u < 113) begin
      s  = u - 110;
      od = (s != 2);
      sc = (s != 0);
    end
    return {sc, od, 1'b1, 1'b0, 4'(entry)};
  endfunction

  // Reference model of start acceptance and elapsed time within a run.
  bit mPrev, mActive, mDone;
  int mT;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mPrev   <= 1'b0;
      mActive <= 1'b0;
      mDone   <= 1'b0;
      mT      <= 0;
    end else begin
      mPrev <= start;
      if (mActive) begin
        if (mT + 1 == TOTAL) begin
          mActive <= 1'b0;
          mDone   <= 1'b1;
        end
        mT <= mT + 1;
      end else if (start && !mPrev) begin
        mActive <= 1'b1;
        mDone   <= 1'b0;
        mT      <= 0;
      end
    end
  end

  // Per-cycle compare against the model, plus busy/done edge timestamps.
  bit prevBusy, prevDone;
  int busyRiseCyc, doneRiseCyc;
  always @(negedge clk) begin
    if (!rst_n) begin
      prevBusy = 1'b0;
      prevDone = 1'b0;
    end else begin
      checkOutput($sformatf("outputs_cyc%0d", cyc), {24'd0, sioc, oe, busy, done, idx},
                  {24'd0, expOut(mActive, mDone, mT)});
      if (busy && !prevBusy) busyRiseCyc = cyc;
      if (done && !prevDone) doneRiseCyc = cyc;
      prevBusy = busy;
      prevDone = done;
    end
  end

  // Bus decoder: start/stop conditions and SIOC-rising samples rebuild each frame.
  bit         prevSioc = 1'b1;
  bit         prevOe   = 1'b0;
  bit         inFrame  = 1'b0;
  bit         lastStopValid = 1'b0;
  int         frIdx = 0;
  int         nbits = 0;
  int         lastStopEntry = 0;
  longint     lastStopTime = 0;
  logic [27:0] sh = '0;
  always @(sioc, oe, rst_n) begin
    if (!rst_n) begin
      inFrame       = 1'b0;
      frIdx         = 0;
      lastStopValid = 1'b0;
    end else begin
      if (sioc && !prevSioc && inFrame) begin
        sh = {sh[26:0], ~oe};
        nbits++;
      end
      if (prevSioc && sioc && oe && !prevOe) begin
        if (inFrame) checkOutput("stray_start", 32'd1, 32'd0);
        if (lastStopValid && lastStopEntry < 7)
          checkOutput($sformatf("gap_after_entry%0d", lastStopEntry),
                      32'(($time - lastStopTime) / 10),
                      (lastStopEntry == 0) ? 32'(5 * D + W) : 32'(5 * D));
        inFrame = 1'b1;
        nbits   = 0;
        sh      = '0;
      end
      if (prevSioc && sioc && !oe && prevOe) begin
        if (!inFrame) begin
          checkOutput("stray_stop", 32'd1, 32'd0);
        end else begin
          checkOutput($sformatf("frame%0d_bits", frIdx), 32'(nbits), 32'd28);
          checkOutput($sformatf("frame%0d_bytes", frIdx), {8'd0, sh[27:20], sh[18:11], sh[9:2]},
                      {8'd0, DEV, subTab[frIdx % 8], datTab[frIdx % 8]});
          checkOutput($sformatf("frame%0d_ninth", frIdx), {29'd0, sh[19], sh[10], sh[1]}, 32'd7);
          lastStopValid = 1'b1;
          lastStopEntry = frIdx % 8;
          lastStopTime  = $time;
          frIdx++;
          inFrame = 1'b0;
        end
      end
    end
    prevSioc = sioc;
    prevOe   = oe;
  end

  // Main stimulus sequence.
  initial begin
    int off;
    rst_n = 1'b0;
    start = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    checkOutput("reset_sioc", {31'd0, sioc}, 32'd1);
    checkOutput("reset_oe",   {31'd0, oe},   32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_idx",  {28'd0, idx},  32'd0);
    #1 rst_n = 1'b1;
    applyStimulus(1'b0, 1000);
    #1;
    checkOutput("idle_bus",    {30'd0, sioc, oe},  32'd2);
    checkOutput("idle_status", {30'd0, busy, done}, 32'd0);

    // Run 1: start held high out of reset, with ignored re-pulses while busy.
    #1 rst_n = 1'b0;
    start = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      repeat ($urandom_range(50, 600)) @(negedge clk);
      applyStimulus(1'b0, $urandom_range(1, 3));
      start = 1'b1;
    end
    waitSig("run1_done", 1, 1'b1, TOTAL + 50);
    checkOutput("run1_frames", 32'(frIdx), 32'd8);
    checkOutput("run1_latency_ok",
                {31'd0, ((doneRiseCyc - busyRiseCyc) >= 3842) && ((doneRiseCyc - busyRiseCyc) <= 3846)},
                32'd1);
    checkOutput("run1_done_idx", {28'd0, idx}, 32'd7);

    // Run 2: fresh rising edge after DONE repeats the whole table.
    applyStimulus(1'b1, $urandom_range(10, 60));
    applyStimulus(1'b0, 2);
    start = 1'b1;
    waitSig("run2_busy", 0, 1'b1, 10);
    checkOutput("run2_done_cleared", {31'd0, done}, 32'd0);
    waitSig("run2_done", 1, 1'b1, TOTAL + 50);
    checkOutput("run2_frames", 32'(frIdx), 32'd16);
    checkOutput("run2_latency_ok",
                {31'd0, ((doneRiseCyc - busyRiseCyc) >= 3842) && ((doneRiseCyc - busyRiseCyc) <= 3846)},
                32'd1);

    // Run 3: reset during bit 5 of entry 3, then restart from entry 0.
    applyStimulus(1'b0, 3);
    start = 1'b1;
    waitSig("run3_busy", 0, 1'b1, 10);
    waitSig("run3_entry3", 2, 1'b1, TOTAL);
    off = $urandom_range(88, 102);
    repeat (off) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset_sioc", {31'd0, sioc}, 32'd1);
    checkOutput("midreset_oe",   {31'd0, oe},   32'd0);
    checkOutput("midreset_busy", {31'd0, busy}, 32'd0);
    checkOutput("midreset_idx",  {28'd0, idx},  32'd0);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b1;
    waitSig("run4_busy", 0, 1'b1, 10);
    checkOutput("run4_idx_start", {28'd0, idx}, 32'd0);
    waitSig("run4_done", 1, 1'b1, TOTAL + 50);
    checkOutput("run4_frames", 32'(frIdx), 32'd8);

    repeat (20) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net in case the sequence stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

endmodule
